// File: rtl/btn_event_gen.sv
// btn_event_gen: turns debounced button levels into press/release/long-press pulses.
// Optional auto-repeat while held: define BTN_AUTOREPEAT_EN.
module btn_event_gen #(
    parameter int NUM_BTN       = 4,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = $clog2(LONG_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] press_p,
    output logic [NUM_BTN-1:0] release_p,
    output logic [NUM_BTN-1:0] long_p,
    output logic [NUM_BTN-1:0] held,
    output logic               any_press
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HELD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_cycles
        $error("btn_event_gen: LONG_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    if ((longint'(REPEAT_CYCLES) - 1) >= (longint'(1) << CNT_W) ||
        (longint'(LONG_CYCLES) - 1) >= (longint'(1) << CNT_W)) begin : g_bad_width
        $error("btn_event_gen: CNT_W too narrow for the cycle counts");
    end

    // Reset high so a button already held at reset release is not a press.
    logic [NUM_BTN-1:0] btn_prev;
    logic [NUM_BTN-1:0] press_set;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_prev  <= '1;
            any_press <= 1'b0;
        end else begin
            btn_prev  <= btn_in;
            any_press <= |press_set;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             press_r;
        logic             rel_r;
        logic             long_r;
        logic             held_r;
        logic             rise;
        logic             rpt_hit;

        assign rise = btn_in[i] & ~btn_prev[i];

`ifdef BTN_AUTOREPEAT_EN
        assign rpt_hit = (state == HELD) && btn_in[i] &&
                         (cnt == REPEAT_LAST);
`else
        assign rpt_hit = 1'b0;
`endif

        assign press_set[i] = ((state == IDLE) && rise) || rpt_hit;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state   <= IDLE;
                cnt     <= '0;
                press_r <= 1'b0;
                rel_r   <= 1'b0;
                long_r  <= 1'b0;
                held_r  <= 1'b0;
            end else begin
                press_r <= press_set[i];
                rel_r   <= 1'b0;
                long_r  <= 1'b0;
                unique case (state)
                    IDLE: begin
                        if (rise) begin
                            state <= PRESS;
                            cnt   <= CNT_ONE;
                        end
                    end
                    PRESS: begin
                        // Release takes priority over reaching the long-press count.
                        if (!btn_in[i]) begin
                            state  <= IDLE;
                            cnt    <= '0;
                            rel_r  <= 1'b1;
                            held_r <= 1'b0;
                        end else if (cnt == LONG_LAST) begin
                            state  <= HELD;
                            cnt    <= '0;
                            long_r <= 1'b1;
                            held_r <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    HELD: begin
                        if (!btn_in[i]) begin
                            state  <= IDLE;
                            cnt    <= '0;
                            rel_r  <= 1'b1;
                            held_r <= 1'b0;
                        end else begin
`ifdef BTN_AUTOREPEAT_EN
                            if (cnt == REPEAT_LAST) begin
                                cnt <= '0;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
`else
                            cnt <= '0;
`endif
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        cnt    <= '0;
                        held_r <= 1'b0;
                    end
                endcase
            end
        end

        assign press_p[i]   = press_r;
        assign release_p[i] = rel_r;
        assign long_p[i]    = long_r;
        assign held[i]      = held_r;
    end

endmodule
